// File: rtl/pipe_hazard_ctrl.sv
// Decode-side sequencing controller: register scoreboard, RAW/WAW stall, redirect flush,
// memory freeze and halt drain. Define PIPE_HAZARD_STALL_COUNT_EN to add the stall_cycles counter.
module pipe_hazard_ctrl #(
    parameter int unsigned NUM_REGS     = 16,
    parameter int unsigned REG_AW       = 4,
    parameter int unsigned LOAD_LAT     = 2,
    parameter int unsigned MUL_LAT      = 4,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    input  logic [REG_AW-1:0]   dec_rs,
    input  logic [REG_AW-1:0]   dec_rq,
    input  logic                dec_rs_used,
    input  logic                dec_rq_used,
    input  logic [REG_AW-1:0]   dec_rd,
    input  logic                dec_rd_write,
    input  logic [1:0]          dec_lat,
    input  logic                dec_halt,
    input  logic                ex_redirect,
    input  logic                mem_busy,
    output logic                pc_stall,
    output logic                dec_stall,
    output logic                dec_flush,
    output logic                ex_bubble,
    output logic                issue,
    output logic                halted,
`ifdef PIPE_HAZARD_STALL_COUNT_EN
    output logic [31:0]         stall_cycles,
`endif
    output logic [NUM_REGS-1:0] busy_mask
);

    localparam int unsigned CW = $clog2(MUL_LAT);
    localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALTED} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q [NUM_REGS];
    logic [CW-1:0]   cnt_d [NUM_REGS];
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CW-1:0]   load_val;
    logic            hazard;
    logic            all_zero;
    logic            freeze;
    logic            sb_write;
    logic            stall_inc;

    always_comb begin
        case (dec_lat)
            2'd1:    load_val = CW'(LOAD_LAT - 1);
            2'd2:    load_val = CW'(MUL_LAT - 1);
            default: load_val = '0;
        endcase
    end

    // WAW only stalls when the older write would land after the new one.
    always_comb begin
        hazard = dec_valid & ((dec_rs_used  & (cnt_q[dec_rs] != '0)) |
                              (dec_rq_used  & (cnt_q[dec_rq] != '0)) |
                              (dec_rd_write & (cnt_q[dec_rd] > load_val)));
    end

    always_comb begin
        all_zero = 1'b1;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            busy_mask[i] = (cnt_q[i] != '0);
            if (cnt_q[i] != '0) all_zero = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pc_stall    = 1'b0;
        dec_stall   = 1'b0;
        dec_flush   = 1'b0;
        ex_bubble   = 1'b0;
        issue       = 1'b0;
        halted      = 1'b0;
        freeze      = 1'b0;
        sb_write    = 1'b0;
        stall_inc   = 1'b0;
        if (rst) begin
            freeze = 1'b0;
        end else if (mem_busy && state_q != HALTED) begin
            pc_stall  = 1'b1;
            dec_stall = 1'b1;
            freeze    = 1'b1;
            stall_inc = (state_q == RUN);
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_redirect) begin
                        dec_flush   = 1'b1;
                        ex_bubble   = 1'b1;
                        state_d     = FLUSH;
                        flush_cnt_d = FW'(FLUSH_CYCLES);
                    end else if (hazard) begin
                        pc_stall  = 1'b1;
                        dec_stall = 1'b1;
                        ex_bubble = 1'b1;
                        stall_inc = 1'b1;
                    end else if (!dec_valid) begin
                        ex_bubble = 1'b1;
                    end else begin
                        issue    = 1'b1;
                        sb_write = dec_rd_write && (load_val != '0);
                        if (dec_halt) begin
                            pc_stall = 1'b1;
                            state_d  = DRAIN;
                        end
                    end
                end
                FLUSH: begin
                    dec_flush = 1'b1;
                    ex_bubble = 1'b1;
                    if (flush_cnt_q != '0) flush_cnt_d = flush_cnt_q - FW'(1);
                    if (flush_cnt_q <= FW'(1)) state_d = RUN;
                end
                DRAIN: begin
                    pc_stall  = 1'b1;
                    dec_stall = 1'b1;
                    ex_bubble = 1'b1;
                    if (all_zero) state_d = HALTED;
                end
                default: begin
                    pc_stall  = 1'b1;
                    dec_stall = 1'b1;
                    ex_bubble = 1'b1;
                    halted    = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!freeze && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CW'(1);
            if (sb_write && dec_rd == REG_AW'(i)) cnt_d[i] = load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef PIPE_HAZARD_STALL_COUNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_inc && stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cycles_q <= '0;
        else     stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`else
    logic unused_stall_inc;
    assign unused_stall_inc = stall_inc;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: scoreboard stalls, flush, memory freeze, halt drain, reset.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [3:0]  dec_rs, dec_rq, dec_rd;
    logic        dec_rs_used, dec_rq_used, dec_rd_write;
    logic [1:0]  dec_lat;
    logic        dec_halt, ex_redirect, mem_busy;
    logic        pc_stall, dec_stall, dec_flush, ex_bubble, issue, halted;
    logic [15:0] busy_mask;
`ifdef PIPE_HAZARD_STALL_COUNT_EN
    logic [31:0] stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    pipe_hazard_ctrl #(
        .NUM_REGS(16), .REG_AW(4), .LOAD_LAT(2), .MUL_LAT(4), .FLUSH_CYCLES(1)
    ) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rq(dec_rq),
        .dec_rs_used(dec_rs_used), .dec_rq_used(dec_rq_used),
        .dec_rd(dec_rd), .dec_rd_write(dec_rd_write), .dec_lat(dec_lat),
        .dec_halt(dec_halt), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .pc_stall(pc_stall), .dec_stall(dec_stall), .dec_flush(dec_flush),
        .ex_bubble(ex_bubble), .issue(issue), .halted(halted),
`ifdef PIPE_HAZARD_STALL_COUNT_EN
        .stall_cycles(stall_cycles),
`endif
        .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ctl bit order: pc_stall dec_stall dec_flush ex_bubble issue halted
    task automatic exp_out(input string tag, input logic [5:0] ctl, input logic [15:0] bm);
        #1;
        chk({tag, ":ctl"}, 32'({pc_stall, dec_stall, dec_flush, ex_bubble, issue, halted}), 32'(ctl));
        chk({tag, ":busy"}, 32'(busy_mask), 32'(bm));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        dec_valid = 0; dec_rs = 0; dec_rq = 0; dec_rs_used = 0; dec_rq_used = 0;
        dec_rd = 0; dec_rd_write = 0; dec_lat = 0; dec_halt = 0;
        ex_redirect = 0; mem_busy = 0;
    endtask

    task automatic wr(input logic [3:0] rd, input logic [1:0] lat);
        idle();
        dec_valid = 1; dec_rd = rd; dec_rd_write = 1; dec_lat = lat;
    endtask

    task automatic rd_src(input logic [3:0] rs);
        idle();
        dec_valid = 1; dec_rs = rs; dec_rs_used = 1; dec_rd = 4'd9; dec_rd_write = 1;
    endtask

    localparam logic [5:0] ISS = 6'b000010, HAZ = 6'b110100, IDL = 6'b000100,
                           MBZ = 6'b110000, FLS = 6'b001100, HLI = 6'b100010,
                           DRN = 6'b110100, HLT = 6'b110101, RST = 6'b000000;

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        exp_out("reset", RST, 16'h0000);
`ifdef PIPE_HAZARD_STALL_COUNT_EN
        chk("reset_stall_cycles", stall_cycles, 32'd0);
`endif
        tick(); rst = 0; idle();               exp_out("run_idle", IDL, 16'h0000);

        // load r3 then dependent read: one bubble
        tick(); wr(4'd3, 2'd1);                exp_out("ld_issue", ISS, 16'h0000);
        tick(); rd_src(4'd3);                  exp_out("raw_stall", HAZ, 16'h0008);
        tick(); rd_src(4'd3);                  exp_out("raw_issue", ISS, 16'h0000);
        tick(); idle();                        exp_out("no_valid", IDL, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick(); idle(); mem_busy = 1;      exp_out("mb_run", MBZ, 16'h0000);
        end
        tick(); idle();                        exp_out("mb_release", IDL, 16'h0000);
`ifdef PIPE_HAZARD_STALL_COUNT_EN
        chk("stall_cycles", stall_cycles, 32'd4);
`endif

        // WAW: multi r5 then ALU r5 stalls three cycles
        tick(); wr(4'd5, 2'd2);                exp_out("mul_issue", ISS, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick(); wr(4'd5, 2'd0);            exp_out("waw_stall", HAZ, 16'h0020);
        end
        tick(); wr(4'd5, 2'd0);                exp_out("waw_issue", ISS, 16'h0000);
        tick(); wr(4'd5, 2'd3);                exp_out("alu_alu", ISS, 16'h0000);
        // older short write under a newer long write: no stall
        tick(); wr(4'd6, 2'd1);                exp_out("ld_r6", ISS, 16'h0000);
        tick(); wr(4'd6, 2'd2);                exp_out("mul_over_ld", ISS, 16'h0040);
        for (int i = 0; i < 3; i++) begin
            tick(); idle();                    exp_out("r6_count", IDL, 16'h0040);
        end
        tick(); idle();                        exp_out("r6_clear", IDL, 16'h0000);

        // redirect with hazard pending; redirect during flush ignored
        tick(); wr(4'd3, 2'd1);                exp_out("ld_r3b", ISS, 16'h0000);
        tick(); rd_src(4'd3); ex_redirect = 1; exp_out("redirect", FLS, 16'h0008);
        tick(); rd_src(4'd3); ex_redirect = 1; exp_out("flush", FLS, 16'h0000);
        tick(); idle();                        exp_out("flush_done", IDL, 16'h0000);

        // memory freeze holds cnt[2] at 2
        tick(); wr(4'd2, 2'd2);                exp_out("mul_r2", ISS, 16'h0000);
        tick(); idle();                        exp_out("r2_cnt3", IDL, 16'h0004);
        for (int i = 0; i < 3; i++) begin
            tick(); idle(); mem_busy = 1;      exp_out("mb_freeze", MBZ, 16'h0004);
        end
        tick(); rd_src(4'd2);                  exp_out("post_mb_2", HAZ, 16'h0004);
        tick(); rd_src(4'd2);                  exp_out("post_mb_1", HAZ, 16'h0004);
        tick(); rd_src(4'd2);                  exp_out("post_mb_iss", ISS, 16'h0000);

        // mem_busy outranks redirect; redirect acted on after release
        tick(); idle(); mem_busy = 1; ex_redirect = 1; exp_out("mb_over_redir", MBZ, 16'h0000);
        tick(); idle(); ex_redirect = 1;       exp_out("redir_late", FLS, 16'h0000);
        tick(); idle();                        exp_out("flush_late", FLS, 16'h0000);
        tick(); idle();                        exp_out("run_again", IDL, 16'h0000);

        // halt with multi-cycle op outstanding
        tick(); wr(4'd7, 2'd2);                exp_out("mul_r7", ISS, 16'h0000);
        tick(); idle(); dec_valid = 1; dec_halt = 1; exp_out("halt_issue", HLI, 16'h0080);
        tick(); idle();                        exp_out("drain_2", DRN, 16'h0080);
        tick(); rd_src(4'd1);                  exp_out("drain_1", DRN, 16'h0080);
        tick(); idle();                        exp_out("drain_0", DRN, 16'h0000);
        tick(); idle();                        exp_out("halted", HLT, 16'h0000);
        tick(); wr(4'd4, 2'd2); mem_busy = 1; ex_redirect = 1; exp_out("halted_hold", HLT, 16'h0000);
        tick(); idle(); rst = 1;               exp_out("rst_in_halt", RST, 16'h0000);
        tick();                                exp_out("rst_held", RST, 16'h0000);
        tick(); rst = 0; idle();               exp_out("after_rst", IDL, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequencing controller for the fetch/decode/execute pipeline; sits beside the decode stage.
- Keeps a per-register scoreboard of in-flight writes and stalls decode on RAW/WAW hazards.
- Flushes wrong-path instructions after a taken jump/branch resolved in execute, freezes everything on a data-memory stall, and drains the pipe on a halt instruction.

Parameters:
- NUM_REGS, 16, architectural register count.
- REG_AW, 4, register index width.
- LOAD_LAT, 2, load result latency in cycles (1..MUL_LAT).
- MUL_LAT, 4, multi-cycle ALU op latency in cycles (>=2).
- FLUSH_CYCLES, 1, extra kill cycles after the redirect cycle (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- dec_valid  in  1  decode holds a valid instruction.
- dec_rs, dec_rq  in  REG_AW  source register indices.
- dec_rs_used, dec_rq_used  in  1  source actually read.
- dec_rd  in  REG_AW  destination index.
- dec_rd_write  in  1  instruction writes dec_rd.
- dec_lat  in  2  0=ALU, 1=load, 2=multi-cycle, 3=treated as ALU.
- dec_halt  in  1  decoded halt opcode.
- ex_redirect  in  1  taken jump/branch in execute; PC mux loads target this cycle.
- mem_busy  in  1  data memory not ready; freeze whole pipe.
- pc_stall  out  1  hold PC.
- dec_stall  out  1  hold decode register.
- dec_flush  out  1  replace decode contents with bubble.
- ex_bubble  out  1  inject NOP into execute.
- issue  out  1  decode instruction advances into execute this cycle.
- halted  out  1  pipeline halted and drained.
- busy_mask  out  NUM_REGS  bit i = scoreboard counter i nonzero.

Behaviour:
- State: FSM {RUN, FLUSH, DRAIN, HALTED}; NUM_REGS down-counters cnt[i], width clog2(MUL_LAT); flush counter.
- Reset: state=RUN, all cnt=0, flush counter=0; outputs (combinational from state) become pc_stall=0, dec_stall=0, dec_flush=0, ex_bubble=0, issue=0, halted=0, busy_mask=0. Reset mid-flush/drain aborts immediately.
- Scoreboard load value: V = 0 (ALU/3), LOAD_LAT-1 (load), MUL_LAT-1 (multi).
- Hazard (combinational) = dec_valid & ((dec_rs_used & cnt[rs]!=0) | (dec_rq_used & cnt[rq]!=0) | (dec_rd_write & cnt[rd] > V)).
- Priority per cycle: rst > mem_busy > ex_redirect > state action > hazard.
- mem_busy=1 (any state except HALTED): pc_stall=dec_stall=1, issue=0, dec_flush=0, ex_bubble=0; counters, FSM and flush counter frozen. A redirect is held by execute and acted on when mem_busy drops.
- RUN, ex_redirect=1: dec_flush=1, ex_bubble=1, issue=0, pc_stall=0; go FLUSH, flush counter=FLUSH_CYCLES. A pending hazard or halt in decode is discarded.
- RUN, hazard: pc_stall=dec_stall=1, ex_bubble=1, issue=0.
- RUN, no hazard, dec_valid, !dec_halt: issue=1; if dec_rd_write and V>0, cnt[rd]<=V next cycle (issue write wins over same-cycle decrement).
- RUN, no hazard, dec_valid & dec_halt: issue=1, pc_stall=1; go DRAIN.
- FLUSH: dec_flush=1, ex_bubble=1, issue=0; ex_redirect ignored; decrement flush counter, return to RUN at 0.
- DRAIN: pc_stall=dec_stall=1, ex_bubble=1; go HALTED once all cnt==0 (same-cycle check on the registered counters).
- HALTED: pc_stall=dec_stall=ex_bubble=halted=1; all inputs ignored until rst.
- Every cycle not frozen: each nonzero cnt decrements by 1 unless reloaded.
- dec_valid=0 in RUN: no stall, issue=0, ex_bubble=1.

Optional Feature:
- Macro PIPE_HAZARD_STALL_COUNT_EN.
- Defined: extra output stall_cycles (32 bits), reset 0, increments in every cycle where dec_stall=1 due to hazard or mem_busy (not in FLUSH/DRAIN/HALTED), and saturates at all-ones.
- Undefined: port and counter absent; all other behaviour is identical.

Test Plan:
- Load r3 (dec_lat=1) issued, next cycle ALU reads rs=r3 -> dec_stall=1 and ex_bubble=1 for 1 cycle (LOAD_LAT=2), issue on 2nd cycle; busy_mask[3] high exactly 1 cycle.
- Multi-cycle write r5, then ALU write r5, no reads -> WAW stall 3 cycles, then issue; ALU after ALU to r5 -> no stall.
- ex_redirect pulse in RUN with hazard pending -> dec_flush=1 for 2 cycles (FLUSH_CYCLES=1), issue=0 throughout, redirect during FLUSH ignored, RUN on 3rd cycle.
- mem_busy for 3 cycles while cnt[2]=2 -> cnt holds at 2, pc_stall=dec_stall=1, issue=0; decrement resumes after release.
- Halt issued with multi-cycle op outstanding (cnt=3) -> DRAIN 3 cycles, then halted=1 and held; rst clears to RUN with all outputs 0.
- With PIPE_HAZARD_STALL_COUNT_EN: the first scenario plus a 3-cycle mem_busy -> stall_cycles=4.
